// File: rtl/rl_ram_req_pkg.sv
// ---------------------------------------------------------------------------
// rl_ram_req_pkg
// Shared constants and helpers for the 1RW RAM request front-end.
//   RSP_DEPTH  : number of entries in the read-response buffer
//   be_width() : byte-lane count for a data width (top lane may be partial)
// The request struct depends on the instantiating module's ABITS/DBITS, so
// it is declared inside that module from these helpers.
// ---------------------------------------------------------------------------
package rl_ram_req_pkg;

   localparam int RSP_DEPTH = 32'sd2;

   // Number of byte lanes covering dbits bits, rounding up.
   function automatic int be_width(input int dbits);
      be_width = (dbits + 32'sd7) / 32'sd8;
   endfunction

endpackage

// File: rtl/rl_ram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// rl_ram_rsp_fifo
// Two-entry synchronous response buffer with registered storage.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (pointers, count and storage to 0)
//   push : write din into the tail
//   pop  : advance the head
//   din  : data written on push
//   dout : data at the head (0 after reset)
//   cnt  : number of valid entries, 0..2
// A push into a full buffer is only accepted when the head leaves in the
// same cycle; anything else is flagged by rl_ram_rsp_fifo_chk.
// ---------------------------------------------------------------------------
module rl_ram_rsp_fifo
   import rl_ram_req_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [DBITS-1:0] din,
   output logic [DBITS-1:0] dout,
   output logic [1:0]       cnt
);

   logic [DBITS-1:0] mem_r [RSP_DEPTH];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       cnt_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify pop against an empty buffer and push against a full one.
   always_comb begin
      do_pop_s  = pop & (cnt_r != 2'd0);
      do_push_s = push & ((cnt_r != 2'd2) | do_pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RSP_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         cnt_r    <= 2'd0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + 2'd1;
            2'b01:   cnt_r <= cnt_r - 2'd1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Head data and occupancy straight from registers.
   always_comb begin
      dout = mem_r[rd_ptr_r];
      cnt  = cnt_r;
   end

   rl_ram_rsp_fifo_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .cnt  (cnt_r)
   );

endmodule

// ---------------------------------------------------------------------------
// rl_ram_rsp_fifo_chk
// Simulation-only properties for the response buffer.
// ---------------------------------------------------------------------------
module rl_ram_rsp_fifo_chk (
   input logic       clk,
   input logic       rst,
   input logic       push,
   input logic       pop,
   input logic [1:0] cnt
);

   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      !(push && (cnt == 2'd2) && !pop));

   a_cnt_range: assert property (@(posedge clk) disable iff (rst)
      (cnt <= 2'd2));

endmodule

// File: rtl/rl_ram_1rw_req_if.sv
// ---------------------------------------------------------------------------
// rl_ram_1rw_req_if
// Valid/ready request front-end for a single-port 1RW RAM with one-cycle
// read latency. Accepted reads are tracked for one cycle (inflight) and
// their RAM data lands in a 2-entry response buffer, so the consumer may
// backpressure without loss. One request per cycle is sustained.
//
// Ports:
//   clk_i, rst_i            : clock; synchronous active-high reset
//   req_valid_i/req_ready_o : request handshake
//   req_we_i, req_addr_i,
//   req_be_i, req_wdata_i   : request payload (be/wdata used by writes)
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_rdata_o             : read data, strictly in acceptance order
//   ram_addr_o, ram_we_o,
//   ram_be_o, ram_din_o     : RAM port drive
//   ram_dout_i              : RAM read data, valid the cycle after a read
//
// Build option: define RL_RAM_RSP_BYPASS_EN to present RAM data directly
// on the response port when the buffer is empty (read latency 1 instead
// of 2). Capacity and ordering are identical in both builds.
// ---------------------------------------------------------------------------
module rl_ram_1rw_req_if
   import rl_ram_req_pkg::*;
#(
   parameter  int ABITS = 10,
   parameter  int DBITS = 32,
   localparam int BEW   = be_width(DBITS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [ABITS-1:0] req_addr_i,
   input  logic [BEW-1:0]   req_be_i,
   input  logic [DBITS-1:0] req_wdata_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [DBITS-1:0] rsp_rdata_o,
   output logic [ABITS-1:0] ram_addr_o,
   output logic             ram_we_o,
   output logic [BEW-1:0]   ram_be_o,
   output logic [DBITS-1:0] ram_din_o,
   input  logic [DBITS-1:0] ram_dout_i
);

   typedef struct packed {
      logic             we;
      logic [ABITS-1:0] addr;
      logic [BEW-1:0]   be;
      logic [DBITS-1:0] wdata;
   } req_t;

   req_t             req_s;
   logic             inflight_r;
   logic             bypass_s;
   logic             pop_s;
   logic             fifo_push_s;
   logic             fifo_pop_s;
   logic [1:0]       cnt_s;
   logic [DBITS-1:0] fifo_dout_s;
   logic [2:0]       occ_s;
   logic             acc_s;
   logic             rd_acc_s;
   logic             wr_acc_s;

   // Response side: valid/data select, pop, and buffer push/pop qualification.
   always_comb begin
`ifdef RL_RAM_RSP_BYPASS_EN
      bypass_s = (cnt_s == 2'd0) & inflight_r;
`else
      bypass_s = 1'b0;
`endif
      rsp_valid_o = ~rst_i & ((cnt_s != 2'd0) | bypass_s);
      if (bypass_s) begin
         rsp_rdata_o = ram_dout_i;
      end else begin
         rsp_rdata_o = fifo_dout_s;
      end
      pop_s = rsp_valid_o & rsp_ready_i;
      // Bypassed data consumed in the same cycle never enters the buffer.
      fifo_push_s = inflight_r & ~(bypass_s & pop_s);
      fifo_pop_s  = pop_s & ~bypass_s;
   end

   // Request side: capacity check counts buffered plus in-flight reads,
   // crediting a pop this cycle (combinational rsp_ready_i -> req_ready_o).
   always_comb begin
      req_s       = '{we: req_we_i, addr: req_addr_i, be: req_be_i, wdata: req_wdata_i};
      occ_s       = {1'b0, cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      req_ready_o = ~rst_i & (occ_s < 3'd2);
      acc_s       = req_valid_i & req_ready_o;
      rd_acc_s    = acc_s & ~req_s.we;
      wr_acc_s    = acc_s & req_s.we;
      ram_addr_o  = req_s.addr;
      ram_din_o   = req_s.wdata;
      ram_be_o    = req_s.be;
      ram_we_o    = wr_acc_s;
   end

   // Marks that the RAM output next cycle belongs to an accepted read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= rd_acc_s;
      end
   end

   rl_ram_rsp_fifo #(
      .DBITS (DBITS)
   ) u_fifo (
      .clk  (clk_i),
      .rst  (rst_i),
      .push (fifo_push_s),
      .pop  (fifo_pop_s),
      .din  (ram_dout_i),
      .dout (fifo_dout_s),
      .cnt  (cnt_s)
   );

endmodule

// File: tb/tb_rl_ram_1rw_req_if.sv
module tb_rl_ram_1rw_req_if;

   localparam int ABITS = 10;
   localparam int DBITS = 32;
   localparam int BEW   = 4;
   localparam int DEPTH = 1024;
`ifdef RL_RAM_RSP_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      logic [31:0] data;
      int          rdy_cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready_o;
   logic             req_we = 1'b0;
   logic [ABITS-1:0] req_addr = '0;
   logic [BEW-1:0]   req_be = '0;
   logic [DBITS-1:0] req_wdata = '0;
   logic             rsp_valid_o;
   logic             rsp_ready = 1'b0;
   logic [DBITS-1:0] rsp_rdata_o;
   logic [ABITS-1:0] ram_addr_o;
   logic             ram_we_o;
   logic [BEW-1:0]   ram_be_o;
   logic [DBITS-1:0] ram_din_o;
   logic [DBITS-1:0] ram_dout;

   logic [31:0] ram_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   bit          init_done = 1'b0;
   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          pop_cnt = 0;
   int          we_cnt = 0;
   logic [31:0] last_rdata = 32'h0;

   rl_ram_1rw_req_if #(.ABITS(ABITS), .DBITS(DBITS)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_be_i    (req_be),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_be_o    (ram_be_o),
      .ram_din_o   (ram_din_o),
      .ram_dout_i  (ram_dout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int a);
      init_val = (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   // Behavioural single-port RAM: byte-enabled write, one-cycle read latency.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_val(i);
      end else if (ram_we_o) begin
         for (int b = 0; b < BEW; b++)
            if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
      end
      ram_dout <= ram_mem[ram_addr_o];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands over a response.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (ram_we_o) we_cnt++;
         if (rsp_valid_o && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_rsp", 32'(rsp_valid_o), 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("rsp_data", rsp_rdata_o, e.data);
               last_rdata = rsp_rdata_o;
               pop_cnt++;
            end
         end
      end
   end

   // One clock of stimulus; the reference model decides acceptance from the
   // number of reads not yet consumed and checks ready/valid against it.
   task automatic do_cycle(input logic v, input logic we, input logic [9:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic rr, output logic acc, output logic rdy_dut);
      logic exp_valid, exp_rdy, pop_now;
      @(negedge clk);
      req_valid = v; req_we = we; req_addr = a; req_be = be; req_wdata = wd; rsp_ready = rr;
      #1;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy_cyc <= cyc);
      pop_now   = exp_valid & rr;
      exp_rdy   = (exp_q.size() - int'(pop_now)) < 2;
      check("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
      check("req_ready", 32'(req_ready_o), 32'(exp_rdy));
      rdy_dut = req_ready_o;
      acc = v & exp_rdy;
      if (acc) begin
         if (we) begin
            for (int b = 0; b < BEW; b++)
               if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
         end else begin
            exp_t e;
            e.data = ref_mem[a];
            e.rdy_cyc = cyc + LAT;
            exp_q.push_back(e);
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      logic acc, rdy;
      for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, acc, rdy);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; rsp_ready = 1'b1;
         #1;
         check("rst_req_ready", 32'(req_ready_o), 32'h0);
         check("rst_ram_we", 32'(ram_we_o), 32'h0);
         check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
         cyc++;
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      #1;
      check("post_rst_valid", 32'(rsp_valid_o), 32'h0);
      check("post_rst_ready", 32'(req_ready_o), 32'h1);
      check("post_rst_rdata", rsp_rdata_o, 32'h0);
      cyc++;
   endtask

   initial begin
      logic acc, rdy, v, we, rr, pending;
      logic [9:0] a;
      logic [3:0] be;
      logic [31:0] wd;
      int lat, we_base, p0, n_rdy, issued;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      @(posedge clk);
      #1 init_done = 1'b1;
      do_reset(2);

      // Write then read the same word; single write strobe, latency LAT.
      we_base = we_cnt;
      do_cycle(1'b1, 1'b1, 10'd5, 4'hF, 32'hDEAD_BEEF, 1'b1, acc, rdy);
      check("wr5_accept", 32'(acc), 32'h1);
      do_cycle(1'b1, 1'b0, 10'd5, 4'h0, 32'h0, 1'b1, acc, rdy);
      lat = 0;
      for (int k = 1; k <= 4; k++) begin
         do_cycle(1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 1'b1, acc, rdy);
         if (lat == 0 && rsp_valid_o) lat = k;
      end
      check("rd_latency", 32'(lat), 32'(LAT));
      check("we_pulses", 32'(we_cnt - we_base), 32'h1);
      check("rdata_addr5", last_rdata, 32'hDEAD_BEEF);

      // Byte-enable merge.
      do_cycle(1'b1, 1'b1, 10'd3, 4'hF, 32'h1122_3344, 1'b1, acc, rdy);
      do_cycle(1'b1, 1'b1, 10'd3, 4'b0101, 32'hAABB_CCDD, 1'b1, acc, rdy);
      do_cycle(1'b1, 1'b0, 10'd3, 4'h0, 32'h0, 1'b1, acc, rdy);
      idle(4);
      check("rdata_be_merge", last_rdata, 32'h11BB_33DD);

      // Backpressure: only two reads fit, third waits for the first pop.
      do_cycle(1'b1, 1'b0, 10'd0, 4'h0, 32'h0, 1'b0, acc, rdy);
      check("bp_rd0_acc", 32'(rdy), 32'h1);
      do_cycle(1'b1, 1'b0, 10'd1, 4'h0, 32'h0, 1'b0, acc, rdy);
      check("bp_rd1_acc", 32'(rdy), 32'h1);
      do_cycle(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b0, acc, rdy);
      check("bp_rd2_stall", 32'(rdy), 32'h0);
      do_cycle(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b0, acc, rdy);
      check("bp_rd2_stall2", 32'(rdy), 32'h0);
      do_cycle(1'b1, 1'b0, 10'd2, 4'h0, 32'h0, 1'b1, acc, rdy);
      check("bp_rd2_on_pop", 32'(rdy), 32'h1);
      idle(4);
      check("bp_rdata_last", last_rdata, init_val(2));

      // Streaming: 16 back-to-back reads, 16 consecutive responses.
      p0 = pop_cnt; n_rdy = 0;
      for (int i = 0; i < 16; i++) begin
         do_cycle(1'b1, 1'b0, 10'(64 + i), 4'h0, 32'h0, 1'b1, acc, rdy);
         if (rdy) n_rdy++;
      end
      idle(LAT);
      #3;
      check("stream_ready", 32'(n_rdy), 32'd16);
      check("stream_pops", 32'(pop_cnt - p0), 32'd16);

      // Reset the cycle after a read is accepted: the read is dropped.
      do_cycle(1'b1, 1'b1, 10'd7, 4'hF, 32'h0BAD_F00D, 1'b1, acc, rdy);
      do_cycle(1'b1, 1'b0, 10'd7, 4'h0, 32'h0, 1'b1, acc, rdy);
      do_reset(1);
      p0 = pop_cnt;
      idle(4);
      check("rst_no_rsp", 32'(pop_cnt - p0), 32'h0);
      do_cycle(1'b1, 1'b0, 10'd7, 4'h0, 32'h0, 1'b1, acc, rdy);
      idle(4);
      check("rst_ram_kept", last_rdata, 32'h0BAD_F00D);

      // Random mixed traffic with random consumer backpressure.
      issued = 0; pending = 1'b0;
      v = 1'b0; we = 1'b0; a = '0; be = '0; wd = '0;
      for (int c = 0; c < 20000 && issued < 1000; c++) begin
         if (!pending) begin
            v  = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 15));
            be = 4'($urandom);
            wd = $urandom;
         end
         rr = ($urandom_range(0, 2) != 0);
         do_cycle(v, we, a, be, wd, rr, acc, rdy);
         if (v) begin
            if (acc) begin
               issued++;
               pending = 1'b0;
            end else begin
               pending = 1'b1;
            end
         end
      end
      check("rand_issued", 32'(issued), 32'd1000);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
      idle(1);
      check("drain_empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rl_ram_1rw_req_if.md
# rl_ram_1rw_req_if

Valid/ready request front-end placed directly upstream of the single-port inferrable 1RW RAM. It turns a streaming read/write request channel into the RAM's single address/write-enable/byte-enable port, and absorbs the RAM's fixed one-cycle read latency. Read data goes through a small response buffer, so a downstream consumer can apply backpressure without losing data. The block sustains one request per cycle.

## Interface
- ABITS, 10, RAM address width (word address)
- DBITS, 32, data width; byte lanes = (DBITS+7)/8, top lane may be partial
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ABITS  word address
- req_be_i  in  (DBITS+7)/8  byte enables (writes only)
- req_wdata_i  in  DBITS  write data
- rsp_valid_o  out  1  read data available
- rsp_ready_i  in  1  consumer takes data when valid&ready
- rsp_rdata_o  out  DBITS  read data
- ram_addr_o  out  ABITS  to RAM addr
- ram_we_o  out  1  to RAM write enable
- ram_be_o  out  (DBITS+7)/8  to RAM byte enables
- ram_din_o  out  DBITS  to RAM write data
- ram_dout_i  in  DBITS  from RAM; valid the cycle after a read is issued

## Operation
- acc = req_valid_i & req_ready_o. rd_acc = acc & ~req_we_i. wr_acc = acc & req_we_i.
- ram_addr_o = req_addr_i, ram_din_o = req_wdata_i, ram_be_o = req_be_i: combinational pass-through.
- ram_we_o = wr_acc. A read is issued every cycle the RAM is addressed; only rd_acc reads are tracked.
- inflight: 1-bit register, set to rd_acc each cycle.
- Response buffer: 2-entry FIFO. cnt is 0..2. Pushed with ram_dout_i when inflight=1, popped on rsp_valid_o & rsp_ready_i (pop).
- req_ready_o = ~rst_i & ((cnt + inflight - pop) < 2). It does not depend on req_valid_i or req_we_i, so writes stall with reads.
- Capacity rule: cnt + inflight never exceeds 2. Push into a full FIFO is impossible by construction; assert it in simulation.
- Ordering: responses are returned strictly in read-acceptance order. Writes produce no response.
- Write then read of the same address on consecutive cycles returns the new data, because the RAM is single-port and handles one op per cycle.
- Simultaneous push and pop with cnt=2: legal. cnt stays 2, and the head advances.
- Reset: cnt=0, inflight=0, FIFO pointers=0, rsp_valid_o=0. req_ready_o=0 and ram_we_o=0 while rst_i=1. A read in flight at reset is discarded. rsp_rdata_o is 0 after reset.

## Timing
- Read accepted at cycle N; RAM data appears at N+1.
- Without bypass: data is pushed at the end of N+1, so rsp_valid_o is high at N+2. Read latency is 2.
- With bypass (see Configuration): rsp_valid_o at N+1 when the FIFO is empty. Read latency is 1.
- Write takes effect at the RAM on the acceptance edge.
- Throughput: 1 read/cycle sustained while rsp_ready_i=1.
- With rsp_ready_i held low: exactly 2 reads are accepted, then req_ready_o=0.
- req_ready_o rises in the same cycle pop occurs. This is a combinational path from rsp_ready_i to req_ready_o.

## Configuration
- Macro RL_RAM_RSP_BYPASS_EN.
- Defined: when cnt=0 and inflight=1, rsp_valid_o=1 and rsp_rdata_o=ram_dout_i combinationally.
  - If popped that cycle, there is no push.
  - Otherwise the data is pushed.
  - This adds a path from ram_dout_i to rsp_rdata_o.
- Undefined: rsp_valid_o = (cnt!=0), and rsp_rdata_o comes from the FIFO head only.
- The capacity rule and ordering are identical in both builds.

## Structure
- Package rl_ram_req_pkg: localparam-style constants RSP_DEPTH=2 and function be_width(DBITS); typedef for the request struct {we, addr, be, wdata}, parameterised through the instantiating module.
- Sub-module rl_ram_rsp_fifo: 2-entry synchronous FIFO (push, pop, din, dout, cnt). Synchronous active-high reset. No internal bypass.
- Top: inflight register, ready/capacity logic, RAM port drive, optional bypass mux.

## Test plan
- Write 0xDEADBEEF to addr 5 with be=4'hF, then read addr 5 with rsp_ready_i=1 → rsp_rdata_o=0xDEADBEEF at N+2 (N+1 with bypass); ram_we_o pulses once.
- Byte enables: write 0x11223344 to addr 3, then write 0xAABBCCDD with be=4'b0101, read addr 3 → 0x11BB33DD.
- Backpressure: reads to addr 0,1,2 with rsp_ready_i=0 → only 0 and 1 accepted, req_ready_o=0. Release → responses in order 0,1, then 2 is accepted.
- Streaming: 16 back-to-back reads with rsp_ready_i=1 → 16 responses on consecutive cycles, req_ready_o never drops.
- Random rsp_ready_i toggling over 1000 mixed requests → scoreboard matches, ordering preserved, push-when-full assertion never fires.
- Reset asserted the cycle after a read is accepted → no response emerges. After reset: rsp_valid_o=0, req_ready_o=1, RAM contents unchanged.
